// File: rtl/tsfm_bus_mixer.sv
// TurboSound-FM style front end: one CPU bus fanned out to NUM_CHIPS YM2203-class cores,
// per-chip FM/PSG enables, and a time-multiplexed saturating mixer with a sample strobe.
module tsfm_bus_mixer #(
  parameter int NUM_CHIPS = 2,
  parameter int FM_W      = 16,
  parameter int PSG_W     = 10,
  parameter int PSG_SHIFT = 4,
  parameter int OUT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    din,
  input  logic                          addr,
  input  logic                          cs_n,
  input  logic                          wr_n,
  output logic [7:0]                    dout,
  output logic [NUM_CHIPS-1:0]          chip_cs_n,
  output logic                          chip_wr_n,
  output logic                          chip_addr,
  output logic [7:0]                    chip_din,
  input  logic [8*NUM_CHIPS-1:0]        chip_dout,
  input  logic [FM_W*NUM_CHIPS-1:0]     fm_snd,
  input  logic [PSG_W*NUM_CHIPS-1:0]    psg_snd,
  input  logic                          chip_sample,
  output logic [1:0]                    sel,
  output logic signed [OUT_W-1:0]       snd,
  output logic                          snd_valid,
  output logic                          overrun
);

  localparam int ACC_W = OUT_W + 3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  localparam logic [1:0] LAST_K = 2'(NUM_CHIPS - 1);

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] top;
    top = v[ACC_W-1:OUT_W-1];
    if (top == '0 || top == '1) return v[OUT_W-1:0];
    else if (v[ACC_W-1])        return {1'b1, {(OUT_W-1){1'b0}}};
    else                        return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // Per-chip views padded to four slots so any 2-bit index stays in range.
  logic [7:0]              dout_arr [4];
  logic signed [FM_W-1:0]  fm_arr   [4];
  logic [PSG_W-1:0]        psg_arr  [4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_chip
    if (gi < NUM_CHIPS) begin : g_on
      assign dout_arr[gi] = chip_dout[gi*8 +: 8];
      assign fm_arr[gi]   = fm_snd[gi*FM_W +: FM_W];
      assign psg_arr[gi]  = psg_snd[gi*PSG_W +: PSG_W];
    end else begin : g_off
      assign dout_arr[gi] = '0;
      assign fm_arr[gi]   = '0;
      assign psg_arr[gi]  = '0;
    end
  end

  logic                   strobe_q, strobe_d;
  logic [1:0]             sel_q, sel_d;
  logic [3:0]             fm_en_q, fm_en_d;
  logic [3:0]             psg_en_q, psg_en_d;
  logic [NUM_CHIPS-1:0]   chip_cs_n_q, chip_cs_n_d;
  logic                   chip_wr_n_q, chip_wr_n_d;
  logic                   chip_addr_q, chip_addr_d;
  logic [7:0]             chip_din_q, chip_din_d;
  logic [7:0]             dout_q, dout_d;
  logic                   sample_q, sample_d;
  logic [1:0]             state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] snd_q, snd_d;
  logic                   snd_valid_q, snd_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   wr_evt, is_ctrl, is_fwd, sample_edge;
  logic [1:0]             ctrl_idx;
  logic signed [ACC_W-1:0] fm_term, psg_term;

  always_comb begin
    strobe_d = ~(cs_n | wr_n);
    wr_evt   = strobe_d & ~strobe_q;
    ctrl_idx = ~din[1:0];
    is_ctrl  = wr_evt && !addr && (din[7:4] == 4'hF);
    is_fwd   = wr_evt && !is_ctrl;

    sel_d    = sel_q;
    fm_en_d  = fm_en_q;
    psg_en_d = psg_en_q;
    // Control bytes naming a chip that is not fitted are dropped without side effects.
    if (is_ctrl && int'(ctrl_idx) < NUM_CHIPS) begin
      sel_d              = ctrl_idx;
      fm_en_d[ctrl_idx]  = din[3];
      psg_en_d[ctrl_idx] = din[2];
    end

    chip_cs_n_d = '1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (is_fwd && int'(sel_q) == i) chip_cs_n_d[i] = 1'b0;
    end
    chip_wr_n_d = ~is_fwd;
    chip_addr_d = is_fwd ? addr : chip_addr_q;
    chip_din_d  = is_fwd ? din  : chip_din_q;
    dout_d      = dout_arr[sel_q];

    sample_d    = chip_sample;
    sample_edge = chip_sample & ~sample_q;
    fm_term     = fm_en_q[k_q]  ? ACC_W'(fm_arr[k_q]) : '0;
    psg_term    = psg_en_q[k_q] ? $signed(ACC_W'(psg_arr[k_q]) << PSG_SHIFT) : '0;

    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    snd_d       = snd_q;
    snd_valid_d = 1'b0;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (sample_edge) begin
          acc_d   = '0;
          k_d     = 2'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + fm_term + psg_term;
        if (k_q == LAST_K) state_d = OUT;
        else               k_d = k_q + 2'd1;
        if (sample_edge) overrun_d = 1'b1;
      end
      OUT: begin
        snd_d       = sat_out(acc_q);
        snd_valid_d = 1'b1;
        state_d     = IDLE;
        if (sample_edge) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q    <= 1'b0;
      sel_q       <= 2'd0;
      fm_en_q     <= '1;
      psg_en_q    <= '1;
      chip_cs_n_q <= '1;
      chip_wr_n_q <= 1'b1;
      dout_q      <= 8'd0;
      sample_q    <= 1'b0;
      state_q     <= IDLE;
      k_q         <= 2'd0;
      acc_q       <= '0;
      snd_q       <= '0;
      snd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      strobe_q    <= strobe_d;
      sel_q       <= sel_d;
      fm_en_q     <= fm_en_d;
      psg_en_q    <= psg_en_d;
      chip_cs_n_q <= chip_cs_n_d;
      chip_wr_n_q <= chip_wr_n_d;
      dout_q      <= dout_d;
      sample_q    <= sample_d;
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      snd_q       <= snd_d;
      snd_valid_q <= snd_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Forwarded address/data only matter while chip_wr_n is low, so they carry no reset.
  always_ff @(posedge clk) begin
    chip_addr_q <= chip_addr_d;
    chip_din_q  <= chip_din_d;
  end

  assign dout      = dout_q;
  assign chip_cs_n = chip_cs_n_q;
  assign chip_wr_n = chip_wr_n_q;
  assign chip_addr = chip_addr_q;
  assign chip_din  = chip_din_q;
  assign sel       = sel_q;
  assign snd       = snd_q;
  assign snd_valid = snd_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tsfm_bus_mixer.sv
// Bench for tsfm_bus_mixer: directed bus/mixer scenarios plus randomized mixes
// compared against an arithmetic reference of the chip-select and mixing rules.
module tb_tsfm_bus_mixer;
  localparam int N         = 2;
  localparam int FM_W      = 16;
  localparam int PSG_W     = 10;
  localparam int PSG_SHIFT = 4;
  localparam int OUT_W     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic [7:0]               din;
  logic                     addr, cs_n, wr_n;
  logic [7:0]               dout;
  logic [N-1:0]             chip_cs_n;
  logic                     chip_wr_n, chip_addr;
  logic [7:0]               chip_din;
  logic [8*N-1:0]           chip_dout;
  logic [FM_W*N-1:0]        fm_snd;
  logic [PSG_W*N-1:0]       psg_snd;
  logic                     chip_sample;
  logic [1:0]               sel;
  logic signed [OUT_W-1:0]  snd;
  logic                     snd_valid, overrun;

  tsfm_bus_mixer #(.NUM_CHIPS(N), .FM_W(FM_W), .PSG_W(PSG_W), .PSG_SHIFT(PSG_SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
    .dout(dout), .chip_cs_n(chip_cs_n), .chip_wr_n(chip_wr_n), .chip_addr(chip_addr),
    .chip_din(chip_din), .chip_dout(chip_dout), .fm_snd(fm_snd), .psg_snd(psg_snd),
    .chip_sample(chip_sample), .sel(sel), .snd(snd), .snd_valid(snd_valid), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int strobe_total = 0;
  int valid_total = 0;

  always @(negedge clk) begin
    if (!chip_wr_n) strobe_total <= strobe_total + 1;
    if (snd_valid)  valid_total  <= valid_total + 1;
  end

  int msel;
  bit mfm_en [4];
  bit mpsg_en [4];
  int mfm [N];
  int mpsg [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    msel = 0;
    for (int i = 0; i < 4; i++) begin
      mfm_en[i]  = 1'b1;
      mpsg_en[i] = 1'b1;
    end
  endtask

  function automatic int ref_mix();
    int s;
    int maxv;
    s = 0;
    maxv = (1 << (OUT_W - 1)) - 1;
    for (int k = 0; k < N; k++) begin
      if (mfm_en[k])  s += mfm[k];
      if (mpsg_en[k]) s += mpsg[k] * (1 << PSG_SHIFT);
    end
    if (s > maxv)      s = maxv;
    if (s < -maxv - 1) s = -maxv - 1;
    return s;
  endfunction

  task automatic cpu_wr(input logic a, input logic [7:0] d);
    bit ctrl;
    int idx;
    logic [N-1:0] ones;
    logic [N-1:0] exp_cs;
    ones = '1;
    ctrl = (a == 1'b0) && (d[7:4] == 4'hF);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    tick();
    cs_n = 1'b1; wr_n = 1'b1;
    if (ctrl) begin
      chk("ctrl_no_wr", chip_wr_n, 1);
      chk("ctrl_no_cs", chip_cs_n, ones);
      idx = 3 - int'(d[1:0]);
      if (idx < N) begin
        msel = idx;
        mfm_en[idx]  = d[3];
        mpsg_en[idx] = d[2];
      end
    end else begin
      exp_cs = ~(N'(1) << msel);
      chk("fwd_wr", chip_wr_n, 0);
      chk("fwd_cs", chip_cs_n, exp_cs);
      chk("fwd_addr", chip_addr, a);
      chk("fwd_din", chip_din, d);
    end
    tick();
    chk("wr_release", chip_wr_n, 1);
    chk("cs_release", chip_cs_n, ones);
    chk("sel", sel, msel);
  endtask

  task automatic run_mix(input string tag);
    int exp;
    int lat;
    for (int k = 0; k < N; k++) begin
      fm_snd[k*FM_W +: FM_W]    = FM_W'(mfm[k]);
      psg_snd[k*PSG_W +: PSG_W] = PSG_W'(mpsg[k]);
    end
    exp = ref_mix();
    lat = -1;
    chip_sample = 1'b1;
    tick();
    chip_sample = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (snd_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, N + 1);
    chk({tag, "_snd"}, snd, exp);
    tick();
    chk({tag, "_valid_drop"}, snd_valid, 0);
  endtask

  initial begin
    int base;
    logic [N-1:0] ones;
    ones = '1;
    rst_n = 1'b0; din = 8'h00; addr = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
    chip_dout = '0; fm_snd = '0; psg_snd = '0; chip_sample = 1'b0;
    model_reset();
    for (int k = 0; k < N; k++) begin mfm[k] = 0; mpsg[k] = 0; end
    repeat (3) tick();
    chk("rst_sel", sel, 0);
    chk("rst_snd", snd, 0);
    chk("rst_valid", snd_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cs", chip_cs_n, ones);
    chk("rst_wr", chip_wr_n, 1);
    rst_n = 1'b1;
    tick();

    // Select chip 1, then a forwarded address/data pair.
    cpu_wr(1'b0, 8'hFE);
    cpu_wr(1'b0, 8'h27);
    cpu_wr(1'b1, 8'h55);

    mfm[0] = 1000; mfm[1] = -300; mpsg[0] = 0; mpsg[1] = 0;
    run_mix("mix700");
    chk("mix700_abs", snd, 700);
    mfm[0] = 32767; mfm[1] = 32767; mpsg[0] = 1023; mpsg[1] = 1023;
    run_mix("sat_hi");
    chk("sat_hi_abs", snd, 32767);
    mfm[0] = -32768; mfm[1] = -32768; mpsg[0] = 0; mpsg[1] = 0;
    run_mix("sat_lo");
    chk("sat_lo_abs", snd, -32768);

    cpu_wr(1'b0, 8'hF3);
    mfm[0] = 5000; mfm[1] = 0; mpsg[0] = 10; mpsg[1] = 0;
    run_mix("muted");
    chk("muted_abs", snd, 0);
    cpu_wr(1'b0, 8'hFF);
    run_mix("unmuted");
    chk("unmuted_abs", snd, 5160);

    for (int it = 0; it < 16; it++) begin
      cpu_wr(1'b0, 8'hF0 | 8'($urandom_range(0, 15)));
      if (it % 3 == 0) cpu_wr(1'($urandom_range(0, 1)), 8'($urandom_range(0, 239)));
      chip_dout = 16'($urandom);
      tick();
      chk("rd_dout", dout, chip_dout[msel*8 +: 8]);
      for (int k = 0; k < N; k++) begin
        mfm[k]  = int'($urandom_range(0, 65535)) - 32768;
        mpsg[k] = int'($urandom_range(0, 1023));
      end
      run_mix("rand");
    end
    chk("no_overrun_yet", overrun, 0);

    // Second trigger while still accumulating.
    base = valid_total;
    chip_sample = 1'b1; tick();
    chip_sample = 1'b0; tick();
    chip_sample = 1'b1; tick();
    chip_sample = 1'b0;
    repeat (8) tick();
    chk("overrun_single_valid", valid_total - base, 1);
    chk("overrun_set", overrun, 1);
    run_mix("after_overrun");
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of accumulation discards the mix.
    base = valid_total;
    chip_sample = 1'b1; tick();
    chip_sample = 1'b0; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    model_reset();
    repeat (8) tick();
    chk("rst_acc_no_valid", valid_total - base, 0);
    chk("rst_acc_snd", snd, 0);
    chk("rst_acc_overrun", overrun, 0);
    chk("rst_acc_sel", sel, 0);

    // A held strobe is a single event.
    base = strobe_total;
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h33;
    repeat (5) tick();
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (2) tick();
    chk("hold_single_strobe", strobe_total - base, 1);

    base = strobe_total;
    cpu_wr(1'b0, 8'hFD);
    tick();
    chk("bad_idx_no_strobe", strobe_total - base, 0);
    mfm[0] = 1234; mfm[1] = -34; mpsg[0] = 5; mpsg[1] = 7;
    run_mix("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
